// File: rtl/bri_pkg.sv
// bri_pkg: shared state encoding, widths and defaults for the bridge pulse controller.
package bri_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_QUAR, S_RUN, S_TURN, S_DONE} state_t;
  localparam int CNT_W = 8;
  localparam int QUAR_DEF = 1;
  localparam int TURN_DEF = 4;
  function automatic state_t skip_to(input logic run_nz, input logic turn_nz);
    return run_nz ? S_RUN : turn_nz ? S_TURN : S_DONE;
  endfunction
endpackage

// File: rtl/bri_pulse_ctrl_if.sv
// bri_pulse_ctrl_if: scheduler-side request bundle and coder-side burst status.
interface bri_pulse_ctrl_if #(parameter int TURN_W = bri_pkg::TURN_DEF);
  logic start;
  logic abort;
  logic [bri_pkg::CNT_W-1:0] pulse_len;
  logic quar_sel;
  logic phase_in;
  logic [TURN_W-1:0] turn_len;
  logic [bri_pkg::CNT_W-1:0] count;
  logic state_start;
  logic quar_delay;
  logic phase;
  logic turn_delay;
  logic busy;
  logic done;
  modport master (
    output start, abort, pulse_len, quar_sel, phase_in, turn_len,
    input  count, state_start, quar_delay, phase, turn_delay, busy, done
  );
  modport slave (
    input  start, abort, pulse_len, quar_sel, phase_in, turn_len,
    output count, state_start, quar_delay, phase, turn_delay, busy, done
  );
endinterface

// File: rtl/bri_tick_cnt.sv
// bri_tick_cnt: quarter sub-tick and carrier-cycle counter, advanced only on enabled ticks.
module bri_tick_cnt
  import bri_pkg::*;
(
  input  logic             clk_dds,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] count,
  output logic             hit
);
  logic [1:0] q;
  assign hit = en && q == 2'd3 && (count + CNT_W'(1)) == len;
  always_ff @(posedge clk_dds or negedge rst_n) begin
    if (!rst_n) begin
      q <= 2'd0;
      count <= '0;
    end else if (clr) begin
      q <= 2'd0;
      count <= '0;
    end else if (en) begin
      q <= q + 2'd1;
      if (q == 2'd3 && count != '1) count <= count + CNT_W'(1);
    end
  end
endmodule

// File: rtl/bri_pulse_ctrl.sv
// bri_pulse_ctrl: sequences one H-bridge burst (WAIT, QUAR, RUN, TURN, DONE) on clk_4f_en ticks.
// Define BRI_PHASE_CYCLE_EN to alternate the burst phase after every completed burst.
module bri_pulse_ctrl
  import bri_pkg::*;
#(
  parameter int TURN_W     = TURN_DEF,
  parameter int QUAR_TICKS = QUAR_DEF
) (
  input logic             clk_dds,
  input logic             rst_n,
  input logic             clk_4f_en,
  bri_pulse_ctrl_if.slave bus
);
  localparam int QW = $clog2(QUAR_TICKS + 1);
  localparam int TMR_W = TURN_W > QW ? TURN_W : QW;
  state_t state, state_n, after_q;
  logic [TMR_W-1:0] tmr, tmr_n;
  logic [CNT_W-1:0] plen, count;
  logic [TURN_W-1:0] tlen;
  logic qsel, phase_r, acc, hit, run_en, cnt_clr;
  assign acc = state == S_IDLE && bus.start && !bus.abort;
  assign after_q = skip_to(plen != '0, tlen != '0);
  assign run_en = clk_4f_en && state == S_RUN;
  assign cnt_clr = bus.abort || state == S_IDLE || state == S_DONE;
  bri_tick_cnt u_tick (
    .clk_dds (clk_dds),
    .rst_n   (rst_n),
    .en      (run_en),
    .clr     (cnt_clr),
    .len     (plen),
    .count   (count),
    .hit     (hit)
  );
  always_comb begin
    state_n = state;
    tmr_n = tmr;
    case (state)
      S_IDLE: state_n = bus.start ? S_WAIT : S_IDLE;
      S_WAIT: state_n = clk_4f_en ? (qsel ? S_QUAR : after_q) : S_WAIT;
      S_QUAR: if (clk_4f_en) begin
        if (tmr == '0) state_n = after_q;
        else tmr_n = tmr - TMR_W'(1);
      end
      S_RUN:  state_n = hit ? (tlen != '0 ? S_TURN : S_DONE) : S_RUN;
      S_TURN: if (clk_4f_en) begin
        if (tmr == '0) state_n = S_DONE;
        else tmr_n = tmr - TMR_W'(1);
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // the delay timer is reloaded on entry so each phase counts its own ticks
    if (state_n == S_QUAR && state != S_QUAR) tmr_n = TMR_W'(QUAR_TICKS - 1);
    if (state_n == S_TURN && state != S_TURN) tmr_n = TMR_W'(tlen) - TMR_W'(1);
    if (bus.abort) state_n = S_IDLE;
  end
  always_ff @(posedge clk_dds or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tmr <= '0;
      plen <= '0;
      tlen <= '0;
      qsel <= 1'b0;
    end else begin
      state <= state_n;
      tmr <= tmr_n;
      if (acc) begin
        plen <= bus.pulse_len;
        tlen <= bus.turn_len;
        qsel <= bus.quar_sel;
      end
    end
  end
`ifdef BRI_PHASE_CYCLE_EN
  logic loaded;
  always_ff @(posedge clk_dds or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= 1'b0;
      loaded <= 1'b0;
    end else if (acc && !loaded) begin
      phase_r <= bus.phase_in;
      loaded <= 1'b1;
    end else if (state == S_DONE && !bus.abort) begin
      phase_r <= ~phase_r;
    end
  end
`else
  always_ff @(posedge clk_dds or negedge rst_n) begin
    if (!rst_n) phase_r <= 1'b0;
    else if (acc) phase_r <= bus.phase_in;
  end
`endif
  assign bus.count = count;
  assign bus.state_start = state == S_QUAR || state == S_RUN;
  assign bus.quar_delay = state == S_QUAR;
  assign bus.turn_delay = state == S_TURN;
  assign bus.busy = state != S_IDLE;
  assign bus.done = state == S_DONE;
  assign bus.phase = state != S_IDLE && phase_r;
endmodule

// File: tb/tb_bri_pulse_ctrl.sv
// tb_bri_pulse_ctrl: randomized bursts, reference expectations queued per start and checked by a monitor.
module tb_bri_pulse_ctrl;
  localparam int TURN_W = 4;
  localparam int QT = 1;
  logic clk_dds = 1'b0;
  logic rst_n = 1'b0;
  logic clk_4f_en = 1'b0;
  bri_pulse_ctrl_if #(.TURN_W(TURN_W)) bus ();
  bri_pulse_ctrl #(.TURN_W(TURN_W), .QUAR_TICKS(QT)) dut (
    .clk_dds   (clk_dds),
    .rst_n     (rst_n),
    .clk_4f_en (clk_4f_en),
    .bus       (bus)
  );
  always #5 clk_dds = ~clk_dds;
  typedef struct {
    bit aborted;
    int run_ticks;
    int quar_ticks;
    int turn_ticks;
    int fin_count;
    bit ph;
  } exp_t;
  exp_t q_exp[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit ph_loaded = 1'b0;
  bit ph_cur = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
  endtask

  // phase expected for the next burst, from the alternation rule or the raw request
  function automatic bit model_phase(input bit pin, input bit ab);
`ifdef BRI_PHASE_CYCLE_EN
    bit r;
    if (!ph_loaded) begin
      ph_cur = pin;
      ph_loaded = 1'b1;
    end
    r = ph_cur;
    if (!ab) ph_cur = ~ph_cur;
    return r;
`else
    return pin | (ab & 1'b0);
`endif
  endfunction

  initial forever begin
    @(posedge clk_dds);
    #1 clk_4f_en = $urandom_range(0, 2) == 0;
  end

  // monitor
  bit in_burst = 0, pend_zero = 0, ph0 = 0, ph_bad = 0, cnt_bad = 0, overlap = 0;
  int rt, qt, tt, last_tick, prev_count;
  exp_t e;
  always @(negedge clk_dds) begin
    cyc++;
    if (!rst_n) in_burst = 0;
    else begin
      if (pend_zero) begin
        chk("count_zero_after_done", bus.count, 0);
        chk("idle_after_done", bus.busy, 0);
        pend_zero = 0;
      end
      if (bus.busy && !in_burst) begin
        chk("burst_expected", q_exp.size() != 0, 1);
        in_burst = 1;
        {rt, qt, tt, prev_count} = '0;
        last_tick = cyc;
        ph0 = bus.phase;
        {ph_bad, cnt_bad, overlap} = '0;
      end
      if (in_burst && bus.busy) begin
        if (bus.phase !== ph0) ph_bad = 1;
        if (bus.count < prev_count || bus.count > prev_count + 1) cnt_bad = 1;
        prev_count = bus.count;
        if (bus.turn_delay && bus.state_start) overlap = 1;
        if (bus.done) begin
          if (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            chk("done_pulse", bus.done, e.aborted ? 0 : 1);
            chk("run_ticks", rt, e.run_ticks);
            chk("quar_ticks", qt, e.quar_ticks);
            chk("turn_ticks", tt, e.turn_ticks);
            chk("final_count", bus.count, e.fin_count);
            chk("phase", ph0, e.ph);
            chk("done_latency", cyc, last_tick + 1);
            chk("phase_stable", ph_bad, 0);
            chk("count_monotonic", cnt_bad, 0);
            chk("start_low_in_turn", overlap, 0);
          end
          in_burst = 0;
          pend_zero = 1;
        end else if (clk_4f_en) begin
          last_tick = cyc;
          if (bus.quar_delay) qt++;
          if (bus.state_start && !bus.quar_delay) rt++;
          if (bus.turn_delay) tt++;
        end
      end else if (in_burst) begin
        if (q_exp.size() != 0) begin
          e = q_exp.pop_front();
          chk("burst_end_kind", bus.done, e.aborted ? 0 : 1);
          chk("abort_phase", ph0, e.ph);
        end
        chk("abort_outputs_zero",
            {bus.count, bus.state_start, bus.quar_delay, bus.phase, bus.turn_delay, bus.done}, 0);
        in_burst = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 20000) begin
      @(negedge clk_dds);
      n++;
    end
    if (bus.busy) begin
      chk("burst_timeout", bus.busy, 0);
      summary();
      $finish;
    end
  endtask

  // am: 0 = run to completion, 1 = abort at count 5 in RUN, 2 = abort a few cycles in
  task automatic burst(input int plen, input bit qs, input bit ph, input int tl, input int am);
    exp_t x;
    int n;
    x.aborted = am != 0;
    x.run_ticks = 4 * plen;
    x.quar_ticks = qs ? QT : 0;
    x.turn_ticks = tl;
    x.fin_count = plen;
    x.ph = model_phase(ph, am != 0);
    q_exp.push_back(x);
    @(posedge clk_dds);
    #1;
    bus.start = 1'b1;
    bus.pulse_len = 8'(plen);
    bus.quar_sel = qs;
    bus.phase_in = ph;
    bus.turn_len = TURN_W'(tl);
    @(posedge clk_dds);
    #1;
    bus.start = 1'b0;
    bus.pulse_len = 8'($urandom);
    bus.quar_sel = 1'($urandom);
    bus.phase_in = 1'($urandom);
    bus.turn_len = TURN_W'($urandom);
    @(negedge clk_dds);
    chk("busy_after_start", bus.busy, 1);
    if (plen >= 2) begin
      @(posedge clk_dds);
      #1 bus.start = 1'b1;
      @(posedge clk_dds);
      #1 bus.start = 1'b0;
    end
    if (am == 1) begin
      n = 0;
      do begin
        @(negedge clk_dds);
        n++;
      end while (!(bus.count == 8'd5 && bus.state_start) && n < 20000);
      bus.abort = 1'b1;
      @(posedge clk_dds);
      #1 bus.abort = 1'b0;
    end else if (am == 2) begin
      repeat ($urandom_range(0, 5)) @(negedge clk_dds);
      bus.abort = 1'b1;
      @(posedge clk_dds);
      #1 bus.abort = 1'b0;
    end
    @(negedge clk_dds);
    wait_idle();
    repeat (2) @(negedge clk_dds);
  endtask

  initial begin
    int pl, tl, am;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.pulse_len = '0;
    bus.quar_sel = 1'b0;
    bus.phase_in = 1'b0;
    bus.turn_len = '0;
    repeat (3) @(negedge clk_dds);
    chk("reset_outputs",
        {bus.count, bus.state_start, bus.quar_delay, bus.phase, bus.turn_delay, bus.busy, bus.done}, 0);
    @(posedge clk_dds);
    #1 rst_n = 1'b1;
    @(negedge clk_dds);
    chk("post_reset_outputs",
        {bus.count, bus.state_start, bus.quar_delay, bus.phase, bus.turn_delay, bus.busy, bus.done}, 0);
    burst(3, 0, 0, 0, 0);
    burst(3, 0, 0, 0, 0);
    burst(3, 0, 0, 0, 0);
    burst(10, 0, 0, 0, 0);
    burst(10, 1, 1, 3, 0);
    burst(0, 0, 0, 0, 0);
    burst(12, 0, 1, 2, 1);
    @(posedge clk_dds);
    #1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk_dds);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk_dds);
    chk("start_abort_idle", bus.busy, 0);
    burst(255, 1, 0, 15, 0);
    repeat (30) begin
      pl = $urandom_range(0, 20);
      tl = $urandom_range(0, 15);
      am = (pl >= 6 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      burst(pl, 1'($urandom), 1'($urandom), tl, am);
    end
    repeat (3) @(negedge clk_dds);
    chk("queue_drained", q_exp.size(), 0);
    chk("final_idle", bus.busy, 0);
    summary();
    $finish;
  end
endmodule
